// File: rtl/dm_bytelane.sv
// dm_bytelane: byte-lane data memory with sized/signed loads, masked stores,
// address-error pulses and an optional clear sweep after reset.
module dm_bytelane #(
  parameter int ADDR_W       = 10,
  parameter bit CLR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [2:0]  Mode,
  input  logic        RE,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        RValid,
  output logic        Busy,
  output logic        AdEL,
  output logic        AdES
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx, idx;
  logic [31:0] mem [DEPTH] = '{default: '0};
  logic        bad, rd_ok, wr_ok;
  logic [3:0]  be;
  logic [31:0] wdata, rword, rext;
  logic [15:0] rhalf;
  logic [7:0]  rbyte;
  always_comb begin
    idx   = A[ADDR_W+1:2];
    bad   = (A >> (ADDR_W + 2)) != 32'd0 || (Mode == 3'd0 && A[1:0] != 2'b00)
            || ((Mode == 3'd1 || Mode == 3'd2) && A[0]) || Mode > 3'd4;
    rd_ok = state == READY && RE && !bad;
    wr_ok = state == READY && WE && !bad;
    be    = Mode == 3'd0 ? 4'hF : Mode <= 3'd2 ? (A[1] ? 4'hC : 4'h3) : 4'b0001 << A[1:0];
    wdata = Mode == 3'd0 ? WD : Mode <= 3'd2 ? {2{WD[15:0]}} : {4{WD[7:0]}};
    rword = mem[idx];
    rbyte = rword[{A[1:0], 3'b000} +: 8];
    rhalf = A[1] ? rword[31:16] : rword[15:0];
    rext  = Mode == 3'd0 ? rword :
            Mode == 3'd1 ? {16'd0, rhalf} :
            Mode == 3'd2 ? {{16{rhalf[15]}}, rhalf} :
            Mode == 3'd3 ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == CLEAR) begin
      cnt_nx   = cnt + 1'b1;
      state_nx = &cnt ? READY : CLEAR;
    end
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= CLR_ON_RESET ? CLEAR : READY;
      cnt    <= '0;
      RD     <= '0;
      RValid <= 1'b0;
      AdEL   <= 1'b0;
      AdES   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      RValid <= rd_ok;
      AdEL   <= state == READY && RE && bad;
      AdES   <= state == READY && WE && bad;
      if (rd_ok) RD <= rext;
    end
  end
  // Array has no reset: Reset only gates writes, the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr_ok)
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
  assign Busy = state == CLEAR;
endmodule

// File: doc/dm_bytelane.md
DM_BYTELANE -- requirements
Module: dm_bytelane

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-index width; DEPTH = 2**ADDR_W words of 32 bits.
REQ-002 SHALL have parameter CLR_ON_RESET, default 1, 1 = sweep-clear array after reset, 0 = skip sweep.
REQ-003 SHALL have ports:
  clk    in   1   clock, all state on rising edge
  Reset  in   1   reset Reset, synchronous, active-high; clock clk
  A      in   32  byte address
  WD     in   32  store data, low-aligned (byte in WD[7:0], half in WD[15:0])
  Mode   in   3   0=word, 1=half unsigned, 2=half signed, 3=byte unsigned, 4=byte signed; 5-7 reserved
  RE     in   1   load request
  WE     in   1   store request
  RD     out  32  load data, extended per Mode
  RValid out  1   one-cycle pulse, RD valid
  Busy   out  1   clear sweep in progress, requests ignored
  AdEL   out  1   one-cycle pulse, load address error
  AdES   out  1   one-cycle pulse, store address error

Function
REQ-004 SHALL have two states: CLEAR (Busy=1) and READY (Busy=0).
REQ-005 CLEAR: SHALL write 0 to word index cnt each cycle, cnt 0..DEPTH-1, then enter READY the cycle after cnt=DEPTH-1; sweep SHALL take exactly DEPTH cycles.
REQ-006 In CLEAR, RE/WE SHALL be ignored: no array write, RValid=AdEL=AdES=0.
REQ-007 Accepted request: RE or WE high in READY; word index = A[ADDR_W+1:2].
REQ-008 Address error: A[31:ADDR_W+2] != 0, or Mode word with A[1:0]!=0, or Mode half with A[0]=1, or Mode 5-7.
REQ-009 Erroneous store SHALL not modify the array and SHALL pulse AdES the next cycle.
REQ-010 Erroneous load SHALL pulse AdEL the next cycle with RValid=0 and RD unchanged.
REQ-011 Store byte enables: word=4'b1111; half=4'b0011 (A[1]=0) or 4'b1100 (A[1]=1); byte=1<<A[1:0]; unenabled lanes SHALL keep old contents.
REQ-012 Store data lane placement: half data replicated to both halves, byte data replicated to all four bytes, before masking.
REQ-013 Load latency SHALL be 1 cycle: RD and RValid registered, valid the cycle after an accepted error-free RE.
REQ-014 Load extraction: select lane by A[1:0] captured with the request; Modes 1,3 zero-extend, Modes 2,4 sign-extend from bit 15/7.
REQ-015 RE and WE same cycle, same word: RD SHALL return pre-write contents (read-before-write); store SHALL still occur.
REQ-016 RE and WE same cycle with error: AdEL and AdES SHALL both pulse; each side judged independently.
REQ-017 RD SHALL hold its last value when RValid=0.
REQ-018 Back-to-back requests SHALL be accepted every cycle with no bubbles.

Reset
REQ-019 Reset high at a rising edge SHALL set RD=0, RValid=0, AdEL=0, AdES=0, cnt=0, and state=CLEAR if CLR_ON_RESET=1 else READY.
REQ-020 Reset during CLEAR SHALL restart sweep from cnt=0; Reset has priority over every request in the same cycle.
REQ-021 Array contents after power-up with CLR_ON_RESET=0 are all-zero (initial value); Reset SHALL not clear them in that mode.

Verification
REQ-022 Reset 1 cycle, ADDR_W=4 -> Busy=1 for exactly 16 cycles; WE at A=0x8 during Busy ignored; later load word 0x8 -> RD=0.
REQ-023 sw 0x11223344 @0x10; sb WD=0xAA @0x12; lw @0x10 -> RD=0x11AA3344 one cycle after RE, RValid pulse 1 cycle.
REQ-024 Word 0x80FF7F01 @0x20: lb @0x23 -> 0xFFFFFF80; lbu @0x23 -> 0x00000080; lh @0x22 -> 0xFFFF80FF; lhu @0x20 -> 0x00007F01.
REQ-025 lw @0x2 -> AdEL pulse, RValid=0; sh @0x1 -> AdES pulse, memory unchanged; sw @(1<<(ADDR_W+2)) -> AdES.
REQ-026 Word 0x5 @0x0, same-cycle RE+WE word 0x9 @0x0 -> RD=0x5; next lw -> RD=0x9.
REQ-027 Reset asserted at cnt=7 of sweep -> sweep restarts, Busy held DEPTH cycles from Reset release.
